// File: rtl/daq_conv_sequencer.sv
// daq_conv_sequencer: programmable-period ADC convert-start sequencer with busy handshake
//
// Issues convert-start pulses every div_i+1 clk_i cycles, waits for all N_ADC busy
// lines to clear, and supports finite bursts (burst_len_i>0) or continuous runs (0).
// Optional macro DAQ_BUSY_SYNC_EN: pass busy_i through a 2-flop synchronizer first.
//
// Ports:
//   clk_i           fabric clock
//   reset_i         asynchronous active-high reset
//   en_i            global enable, low aborts to IDLE (count and sticky flags kept)
//   start_i         start strobe, accepted in IDLE only
//   div_i           period divisor, rising edges div_i+1 cycles apart
//   burst_len_i     conversions per burst, 0 = continuous
//   busy_i          per-ADC busy, high while converting
//   conv_o          registered convert-start pulse, PULSE_W cycles wide
//   sample_valid_o  one-cycle pulse once all busy lines cleared
//   active_o        high outside IDLE
//   done_o          one-cycle pulse at burst completion
//   overrun_o       sticky, period tick arrived while a conversion was outstanding
//   timeout_o       sticky, busy failed to clear within TO_CYC cycles
//   conv_cnt_o      conversions issued in the current burst
module daq_conv_sequencer #(
   parameter int DIV_W   = 16,
   parameter int CNT_W   = 16,
   parameter int N_ADC   = 2,
   parameter int PULSE_W = 4,
   parameter int TO_CYC  = 255
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic             start_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic [CNT_W-1:0] burst_len_i,
   input  logic [N_ADC-1:0] busy_i,
   output logic             conv_o,
   output logic             sample_valid_o,
   output logic             active_o,
   output logic             done_o,
   output logic             overrun_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] conv_cnt_o
);
   localparam int PW_W = $clog2(PULSE_W + 1);
   localparam int TO_W = $clog2(TO_CYC + 1);

   typedef enum logic [1:0] {IDLE, PULSE, WAIT_BUSY, GAP} state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d, tmr_q, tmr_d;
   logic [CNT_W-1:0] blen_q, blen_d, cnt_q, cnt_d;
   logic [PW_W-1:0]  pcnt_q, pcnt_d;
   logic [TO_W-1:0]  tocnt_q, tocnt_d;
   logic             conv_q, conv_d, sv_q, sv_d, done_q, done_d;
   logic             ovr_q, ovr_d, to_q, to_d;
   logic [N_ADC-1:0] busy_w;
   logic             tick, clear, burst_done, issue;

`ifdef DAQ_BUSY_SYNC_EN
   logic [N_ADC-1:0] bs1_q, bs2_q;
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         bs1_q <= '0;
         bs2_q <= '0;
      end else begin
         bs1_q <= busy_i;
         bs2_q <= bs1_q;
      end
   assign busy_w = bs2_q;
`else
   assign busy_w = busy_i;
`endif

   // The period timer free-runs from the first pulse; a tick is its zero count.
   assign tick       = (tmr_q == '0) && (state_q != IDLE);
   assign clear      = ~|busy_w;
   assign burst_done = (blen_q != '0) && (cnt_q == blen_q);
   // Done has priority over a coincident tick in GAP.
   assign issue      = en_i && ((state_q == IDLE && start_i) || (state_q == GAP && !burst_done && tick));

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      blen_d  = blen_q;
      cnt_d   = cnt_q;
      pcnt_d  = pcnt_q;
      tocnt_d = tocnt_q;
      conv_d  = conv_q;
      sv_d    = 1'b0;
      done_d  = 1'b0;
      ovr_d   = ovr_q;
      to_d    = to_q;
      tmr_d   = (state_q == IDLE) ? tmr_q : (tick ? div_q : tmr_q - DIV_W'(1));
      if (!en_i) begin
         state_d = IDLE;
         conv_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (start_i) begin
               blen_d = burst_len_i;
               ovr_d  = 1'b0;
               to_d   = 1'b0;
            end
            PULSE: begin
               ovr_d = ovr_q | tick;
               if (pcnt_q == '0) begin
                  conv_d  = 1'b0;
                  tocnt_d = '0;
                  state_d = WAIT_BUSY;
               end else
                  pcnt_d = pcnt_q - PW_W'(1);
            end
            WAIT_BUSY: begin
               ovr_d = ovr_q | tick;
               // A clear in the expiry cycle still counts as a good sample.
               if (clear) begin
                  sv_d    = 1'b1;
                  state_d = GAP;
               end else if (tocnt_q == TO_W'(TO_CYC - 1)) begin
                  to_d    = 1'b1;
                  state_d = GAP;
               end else
                  tocnt_d = tocnt_q + TO_W'(1);
            end
            GAP: if (burst_done) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         endcase
         if (issue) begin
            state_d = PULSE;
            conv_d  = 1'b1;
            pcnt_d  = PW_W'(PULSE_W - 1);
            div_d   = div_i;
            tmr_d   = div_i;
            cnt_d   = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         state_q <= IDLE;
         div_q   <= '0;
         blen_q  <= '0;
         tmr_q   <= '0;
         cnt_q   <= '0;
         pcnt_q  <= '0;
         tocnt_q <= '0;
         conv_q  <= 1'b0;
         sv_q    <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         blen_q  <= blen_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         pcnt_q  <= pcnt_d;
         tocnt_q <= tocnt_d;
         conv_q  <= conv_d;
         sv_q    <= sv_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
         to_q    <= to_d;
      end

   assign conv_o         = conv_q;
   assign sample_valid_o = sv_q;
   assign active_o       = state_q != IDLE;
   assign done_o         = done_q;
   assign overrun_o      = ovr_q;
   assign timeout_o      = to_q;
   assign conv_cnt_o     = cnt_q;
endmodule

// File: tb/tb_daq_conv_sequencer.sv
// tb_daq_conv_sequencer: self-checking bench for daq_conv_sequencer
module tb_daq_conv_sequencer;
   localparam int DIV_W = 16, CNT_W = 16, N_ADC = 2, PW = 4, TO_CYC = 255;
`ifdef DAQ_BUSY_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic             clk = 1'b0, rst, en, start;
   logic [DIV_W-1:0] div;
   logic [CNT_W-1:0] blen;
   logic [N_ADC-1:0] busy;
   logic             conv, sv, act, done, ovr, tmo;
   logic [CNT_W-1:0] cnt;
   int               cyc = 0, n_cmp = 0, n_err = 0;
   int               b_tab[16];

   daq_conv_sequencer #(.DIV_W(DIV_W), .CNT_W(CNT_W), .N_ADC(N_ADC), .PULSE_W(PW), .TO_CYC(TO_CYC)) dut (
      .clk_i(clk), .reset_i(rst), .en_i(en), .start_i(start), .div_i(div), .burst_len_i(blen),
      .busy_i(busy), .conv_o(conv), .sample_valid_o(sv), .active_o(act), .done_o(done),
      .overrun_o(ovr), .timeout_o(tmo), .conv_cnt_o(cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected event cycles are derived arithmetically per conversion: a pulse starting
   // in cycle r lasts PW cycles, busy clears w cycles into the wait, the gap begins the
   // cycle after, ticks fall every d+1 cycles, and the next pulse follows the first
   // tick seen at or after the gap begins.
   task automatic run_case(input string nm, input int d, input int L, input logic [N_ADC-1:0] pat, input int n);
      int er[$], es[$], orr[$], os[$];
      int ed, eo, et, hz, r, g, w, t, s, od, nd, oo, ot, hi, ehi, ac, eac, bl, j, ne, nse;
      logic pc;
      s = cyc; r = s + 1; ed = -1; eo = -1; et = -1;
      for (int k = 0; k < n; k++) begin
         er.push_back(r);
         w = b_tab[k] + LAT;
         g = r + PW + ((w < TO_CYC) ? w : TO_CYC - 1) + 1;
         if (w < TO_CYC) es.push_back(g);
         else if (et < 0) et = g;
         if (eo < 0 && r + d < g) eo = r + d + 1;
         if (L != 0 && k == L - 1) begin
            ed = g + 1;
            break;
         end
         t = r + d;
         while (t < g) t += d + 1;
         r = t + 1;
      end
      hz = (L != 0) ? ed + 3 : er[n-1] + 2;
      if (eo >= hz) eo = -1;
      if (et >= hz) et = -1;
      ne = 0; ehi = 0; nse = 0;
      foreach (er[i]) if (er[i] < hz) begin
         ne++;
         ehi += (hz - er[i] < PW) ? hz - er[i] : PW;
      end
      foreach (es[i]) if (es[i] < hz) nse++;
      eac = ((L != 0) ? ed : hz) - (s + 1);
      div = DIV_W'(d); blen = CNT_W'(L);
      pc = 1'b0; od = -1; nd = 0; oo = -1; ot = -1; hi = 0; ac = 0; bl = 0; j = 0;
      for (int c = s; c < hz; c++) begin
         if (conv && !pc) orr.push_back(c);
         if (conv) hi++;
         if (sv) os.push_back(c);
         if (done) begin
            nd++;
            if (od < 0) od = c;
         end
         if (act) ac++;
         if (c > s && ovr && oo < 0) oo = c;
         if (c > s && tmo && ot < 0) ot = c;
         start = (c == s) || (c == s + 3);
         if (conv && !pc) begin
            bl = (j < 16) ? b_tab[j] : 0;
            j++;
         end
         busy = (conv || bl > 0) ? pat : '0;
         if (!conv && bl > 0) bl--;
         pc = conv;
         @(negedge clk);
      end
      start = 1'b0;
      n_cmp++;
      if (orr.size() !== ne) begin n_err++; $display("FAIL %s rise_count: got %0d expected %0d", nm, orr.size(), ne); end
      for (int i = 0; i < ne && i < orr.size(); i++) begin
         n_cmp++;
         if (orr[i] - s !== er[i] - s) begin n_err++; $display("FAIL %s rise[%0d]: got cycle %0d expected %0d", nm, i, orr[i] - s, er[i] - s); end
      end
      n_cmp++;
      if (hi !== ehi) begin n_err++; $display("FAIL %s conv_high_cycles: got %0d expected %0d", nm, hi, ehi); end
      n_cmp++;
      if (os.size() !== nse) begin n_err++; $display("FAIL %s sample_valid_count: got %0d expected %0d", nm, os.size(), nse); end
      for (int i = 0; i < nse && i < os.size(); i++) begin
         n_cmp++;
         if (os[i] - s !== es[i] - s) begin n_err++; $display("FAIL %s sample_valid[%0d]: got cycle %0d expected %0d", nm, i, os[i] - s, es[i] - s); end
      end
      n_cmp++;
      if (nd !== ((L != 0) ? 1 : 0)) begin n_err++; $display("FAIL %s done_count: got %0d expected %0d", nm, nd, (L != 0) ? 1 : 0); end
      if (L != 0) begin
         n_cmp++;
         if (od - s !== ed - s) begin n_err++; $display("FAIL %s done_cycle: got %0d expected %0d", nm, od - s, ed - s); end
      end
      n_cmp++;
      if (((oo < 0) ? -1 : oo - s) !== ((eo < 0) ? -1 : eo - s)) begin
         n_err++; $display("FAIL %s overrun_set_cycle: got %0d expected %0d", nm, (oo < 0) ? -1 : oo - s, (eo < 0) ? -1 : eo - s);
      end
      n_cmp++;
      if (((ot < 0) ? -1 : ot - s) !== ((et < 0) ? -1 : et - s)) begin
         n_err++; $display("FAIL %s timeout_set_cycle: got %0d expected %0d", nm, (ot < 0) ? -1 : ot - s, (et < 0) ? -1 : et - s);
      end
      n_cmp++;
      if (ac !== eac) begin n_err++; $display("FAIL %s active_cycles: got %0d expected %0d", nm, ac, eac); end
      n_cmp++;
      if (cnt !== CNT_W'((L != 0) ? L : n)) begin n_err++; $display("FAIL %s conv_cnt: got %0d expected %0d", nm, cnt, (L != 0) ? L : n); end
   endtask

   task automatic check_all_zero(input string nm);
      n_cmp++;
      if ({conv, sv, act, done, ovr, tmo} !== 6'b0 || cnt !== '0) begin
         n_err++;
         $display("FAIL %s outputs: got conv=%b sv=%b act=%b done=%b ovr=%b tmo=%b cnt=%0d expected all 0", nm, conv, sv, act, done, ovr, tmo, cnt);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b1; start = 1'b0; busy = '0; div = '0; blen = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset_held");
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset_released");
   endtask

   task automatic test_finite_burst;
      foreach (b_tab[i]) b_tab[i] = 3;
      run_case("finite_burst", 9, 3, 2'b11, 3);
   endtask

   task automatic test_overrun;
      foreach (b_tab[i]) b_tab[i] = 8;
      run_case("overrun", 5, 3, 2'b11, 3);
   endtask

   task automatic test_timeout;
      foreach (b_tab[i]) b_tab[i] = 2;
      b_tab[0] = 300;
      run_case("timeout", 9, 2, 2'b01, 2);
   endtask

   task automatic test_div_zero;
      foreach (b_tab[i]) b_tab[i] = 1;
      run_case("div_zero", 0, 3, 2'b10, 3);
   endtask

   task automatic test_abort;
      int s, bad;
      busy = '0; div = DIV_W'(9); blen = CNT_W'(5); s = cyc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < s + 11) @(negedge clk);
      n_cmp++;
      if (conv !== 1'b1) begin n_err++; $display("FAIL abort_second_pulse: conv_o=%b expected 1", conv); end
      en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (conv !== 1'b0 || act !== 1'b0) begin n_err++; $display("FAIL abort_stop: conv_o=%b active_o=%b expected 0 0", conv, act); end
      n_cmp++;
      if (cnt !== CNT_W'(2)) begin n_err++; $display("FAIL abort_cnt: got %0d expected 2", cnt); end
      bad = 0;
      repeat (20) begin
         if (done || conv || act) bad++;
         @(negedge clk);
      end
      n_cmp++;
      if (bad !== 0 || cnt !== CNT_W'(2)) begin n_err++; $display("FAIL abort_quiet: activity cycles %0d cnt %0d expected 0 and 2", bad, cnt); end
      en = 1'b1;
   endtask

   task automatic test_continuous_reset;
      foreach (b_tab[i]) b_tab[i] = 2;
      run_case("continuous", 9, 0, 2'b10, 4);
      n_cmp++;
      if (conv !== 1'b1) begin n_err++; $display("FAIL cont_mid_pulse: conv_o=%b expected 1", conv); end
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_case("restart", 7, 2, 2'b11, 2);
   endtask

   task automatic test_random;
      for (int it = 0; it < 6; it++) begin
         int d, L;
         logic [N_ADC-1:0] p;
         d = $urandom_range(0, 15);
         L = $urandom_range(1, 4);
         p = N_ADC'($urandom_range(1, (1 << N_ADC) - 1));
         foreach (b_tab[i]) b_tab[i] = $urandom_range(0, 12);
         run_case("random", d, L, p, L);
      end
   endtask

   initial begin
      test_reset();
      test_finite_burst();
      test_overrun();
      test_timeout();
      test_abort();
      test_div_zero();
      test_continuous_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
